// File: rtl/debounce_fsm_multi_if.sv
// debounce_fsm_multi_if: pin-side bundle of the debouncer.
// master drives en/sw_in; slave returns db_level/rise/fall.
interface debounce_fsm_multi_if #(
  parameter int N_CH = 4
);
  logic            en;
  logic [N_CH-1:0] sw_in;
  logic [N_CH-1:0] db_level;
  logic [N_CH-1:0] rise_tick;
  logic [N_CH-1:0] fall_tick;

  modport master (
    output en,
    output sw_in,
    input  db_level,
    input  rise_tick,
    input  fall_tick
  );

  modport slave (
    input  en,
    input  sw_in,
    output db_level,
    output rise_tick,
    output fall_tick
  );
endinterface

// File: rtl/debounce_fsm_multi.sv
// debounce_fsm_multi: N-channel debouncer, one FSM per channel,
// shared prescaler tick. Ports: clk, reset (async, high), bus.
// bus.en runs the prescaler, bus.sw_in raw pins, bus.db_level
// clean level, bus.rise_tick/fall_tick 1-cycle accepted edges.
module debounce_fsm_multi #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 100000,
  parameter int N_TICKS  = 10
) (
  input logic                 clk,
  input logic                 reset,
  debounce_fsm_multi_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int QW = $clog2(N_TICKS + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TICK_DIV - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(N_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sw_s;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  state_t        state_reg [N_CH];
  state_t        state_nxt [N_CH];
  logic [QW-1:0] q_reg     [N_CH];
  logic [QW-1:0] q_nxt     [N_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sw_s  <= '0;
    end else begin
      sync1 <= bus.sw_in;
      sw_s  <= sync1;
    end
  end

  assign tick = bus.en && (tick_cnt == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (bus.en) begin
      if (tick_cnt == T_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        state_reg[c] <= ZERO;
        q_reg[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_reg[c] <= state_nxt[c];
        q_reg[c]     <= q_nxt[c];
      end
    end
  end

  // Input reversal is tested before tick so an abort
  // always wins over a completing wait.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      state_nxt[c] = state_reg[c];
      q_nxt[c]     = q_reg[c];
      rise[c]      = 1'b0;
      fall[c]      = 1'b0;
      case (state_reg[c])
        ZERO: begin
          if (sw_s[c]) begin
            state_nxt[c] = WAIT1;
            q_nxt[c]     = '0;
          end
        end
        WAIT1: begin
          if (!sw_s[c]) begin
            state_nxt[c] = ZERO;
          end else if (tick) begin
            if (q_reg[c] == Q_LAST) begin
              state_nxt[c] = ONE;
              rise[c]      = 1'b1;
            end else begin
              q_nxt[c] = q_reg[c] + QW'(1);
            end
          end
        end
        ONE: begin
          if (!sw_s[c]) begin
            state_nxt[c] = WAIT0;
            q_nxt[c]     = '0;
          end
        end
        WAIT0: begin
          if (sw_s[c]) begin
            state_nxt[c] = ONE;
          end else if (tick) begin
            if (q_reg[c] == Q_LAST) begin
              state_nxt[c] = ZERO;
              fall[c]      = 1'b1;
            end else begin
              q_nxt[c] = q_reg[c] + QW'(1);
            end
          end
        end
        default: state_nxt[c] = ZERO;
      endcase
    end
  end

  // ONE and WAIT0 share the high encoding bit.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      bus.db_level[c] = state_reg[c][1];
    end
  end

  assign bus.rise_tick = rise;
  assign bus.fall_tick = fall;
endmodule

// File: tb/tb_debounce_fsm_multi.sv
// tb_debounce_fsm_multi: scenario tasks plus a run-length
// reference model of the debouncer, checked every cycle.
module tb_debounce_fsm_multi;
  localparam int N_CH     = 4;
  localparam int TICK_DIV = 4;
  localparam int N_TICKS  = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  debounce_fsm_multi_if #(.N_CH(N_CH)) bus ();

  debounce_fsm_multi #(
    .N_CH    (N_CH),
    .TICK_DIV(TICK_DIV),
    .N_TICKS (N_TICKS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Model: level per channel, whether the input has already
  // disagreed for a full cycle (run), and ticks seen in the run.
  logic [N_CH-1:0] m_p1 = '0;
  logic [N_CH-1:0] m_s = '0;
  logic [N_CH-1:0] m_level = '0;
  logic [N_CH-1:0] m_run = '0;
  int              m_ticks [N_CH];
  int              m_cnt = 0;
  logic [N_CH-1:0] exp_level;
  logic [N_CH-1:0] exp_rise;
  logic [N_CH-1:0] exp_fall;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p1 = '0;
      m_s = '0;
      m_level = '0;
      m_run = '0;
      m_cnt = 0;
      for (int c = 0; c < N_CH; c++) m_ticks[c] = 0;
    end else begin
      automatic bit tk = bus.en && (m_cnt == TICK_DIV - 1);
      for (int c = 0; c < N_CH; c++) begin
        if (m_s[c] == m_level[c]) begin
          m_run[c] = 1'b0;
          m_ticks[c] = 0;
        end else if (!m_run[c]) begin
          m_run[c] = 1'b1;
          m_ticks[c] = 0;
        end else if (tk) begin
          if (m_ticks[c] == N_TICKS - 1) begin
            m_level[c] = ~m_level[c];
            m_run[c] = 1'b0;
            m_ticks[c] = 0;
          end else begin
            m_ticks[c]++;
          end
        end
      end
      if (bus.en) m_cnt = (m_cnt + 1) % TICK_DIV;
      m_s = m_p1;
      m_p1 = bus.sw_in;
    end
  end

  always_comb begin
    automatic bit tk = bus.en && (m_cnt == TICK_DIV - 1);
    exp_level = m_level;
    exp_rise = '0;
    exp_fall = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (m_s[c] != m_level[c] && m_run[c] && tk &&
          m_ticks[c] == N_TICKS - 1) begin
        exp_rise[c] = !m_level[c];
        exp_fall[c] = m_level[c];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b1;
    bus.sw_in = 4'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.db_level !== 4'b0) begin
      errors++;
      $display("FAIL reset_level got=%b exp=0000", bus.db_level);
    end
    checks++;
    if (bus.rise_tick !== 4'b0) begin
      errors++;
      $display("FAIL reset_rise got=%b exp=0000", bus.rise_tick);
    end
    checks++;
    if (bus.fall_tick !== 4'b0) begin
      errors++;
      $display("FAIL reset_fall got=%b exp=0000", bus.fall_tick);
    end
    bus.sw_in = '0;
    reset = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_press();
    int lat = 0;
    int npulse = 0;
    bus.sw_in[0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL press_model n=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          n, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      if (bus.rise_tick[0]) begin
        npulse++;
        if (lat == 0) lat = n;
      end
    end
    checks++;
    if (lat < 11 || lat > 14) begin
      errors++;
      $display("FAIL press_latency got=%0d exp=11..14", lat);
    end
    checks++;
    if (npulse != 1) begin
      errors++;
      $display("FAIL press_pulses got=%0d exp=1", npulse);
    end
    checks++;
    if (bus.db_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL press_level got=%b exp=1", bus.db_level[0]);
    end
  endtask

  task automatic test_bounce();
    int npulse = 0;
    int nlevel = 0;
    for (int i = 0; i < 60; i++) begin
      bus.sw_in[1] = (i < 40) && ((i / 5) % 2 == 0);
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL bounce_model i=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          i, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      if (bus.rise_tick[1] || bus.fall_tick[1]) npulse++;
      if (bus.db_level[1]) nlevel++;
    end
    checks++;
    if (npulse != 0 || nlevel != 0) begin
      errors++;
      $display("FAIL bounce_quiet got pulses=%0d high=%0d exp 0 0",
        npulse, nlevel);
    end
  endtask

  task automatic test_release();
    int lat = 0;
    int npulse = 0;
    int dropped_early = 0;
    bus.sw_in[0] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL release_model n=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          n, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      if (lat == 0 && !bus.db_level[0]) dropped_early++;
      if (bus.fall_tick[0]) begin
        npulse++;
        if (lat == 0) lat = n;
      end
    end
    checks++;
    if (lat < 11 || lat > 14) begin
      errors++;
      $display("FAIL release_latency got=%0d exp=11..14", lat);
    end
    checks++;
    if (npulse != 1 || dropped_early != 0) begin
      errors++;
      $display("FAIL release_shape got pulses=%0d early_low=%0d exp 1 0",
        npulse, dropped_early);
    end
    checks++;
    if (bus.db_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_level got=%b exp=0", bus.db_level[0]);
    end
  endtask

  task automatic test_simultaneous();
    int r1 = 0;
    int r3 = 0;
    int other = 0;
    bus.sw_in = 4'b1010;
    for (int n = 1; n <= 40; n++) begin
      if (n == 21) bus.sw_in = 4'b0000;
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL simul_model n=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          n, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      if (bus.rise_tick[1] && r1 == 0) r1 = n;
      if (bus.rise_tick[3] && r3 == 0) r3 = n;
      if (bus.rise_tick[0] || bus.rise_tick[2] ||
          bus.fall_tick[0] || bus.fall_tick[2]) other++;
    end
    checks++;
    if (r1 == 0 || r1 != r3) begin
      errors++;
      $display("FAIL simul_same_cycle got ch1=%0d ch3=%0d exp equal nonzero",
        r1, r3);
    end
    checks++;
    if (other != 0) begin
      errors++;
      $display("FAIL simul_others got pulses=%0d exp=0", other);
    end
  endtask

  task automatic test_enable();
    int seen = 0;
    int lat = 0;
    bus.en = 1'b0;
    bus.sw_in = 4'b0100;
    for (int n = 1; n <= 100; n++) begin
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL enable_off_model n=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          n, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      if (bus.db_level[2] || bus.rise_tick != 4'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL enable_frozen got events=%0d exp=0", seen);
    end
    bus.en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL enable_on_model n=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          n, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      if (bus.rise_tick[2] && lat == 0) lat = n;
    end
    checks++;
    if (lat < 9 || lat > 12) begin
      errors++;
      $display("FAIL enable_latency got=%0d exp=9..12", lat);
    end
    bus.sw_in = 4'b0000;
    repeat (20) step();
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    int lat = 0;
    bus.sw_in = 4'b0001;
    while (!(m_run[0] && m_ticks[0] == 2) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL midwait_reach got cycles=%0d exp <40", n);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.db_level, bus.rise_tick, bus.fall_tick} !== 12'b0) begin
      errors++;
      $display("FAIL midwait_reset got l=%b r=%b f=%b exp all 0",
        bus.db_level, bus.rise_tick, bus.fall_tick);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.db_level, bus.rise_tick, bus.fall_tick} !== 12'b0) begin
      errors++;
      $display("FAIL midwait_hold got l=%b r=%b f=%b exp all 0",
        bus.db_level, bus.rise_tick, bus.fall_tick);
    end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL midwait_model k=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          k, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      if (bus.rise_tick[0] && lat == 0) lat = k;
    end
    checks++;
    if (lat < 11 || lat > 14) begin
      errors++;
      $display("FAIL midwait_fresh_latency got=%0d exp=11..14", lat);
    end
    bus.sw_in = 4'b0000;
    repeat (20) step();
  endtask

  task automatic test_random();
    int edges = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 19) == 0) bus.sw_in[c] = ~bus.sw_in[c];
      end
      bus.en = ($urandom_range(0, 15) != 0);
      step();
      checks++;
      if ({bus.db_level, bus.rise_tick, bus.fall_tick} !==
          {exp_level, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL random_model n=%0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
          n, bus.db_level, bus.rise_tick, bus.fall_tick,
          exp_level, exp_rise, exp_fall);
      end
      checks++;
      if ((bus.rise_tick & bus.fall_tick) !== 4'b0) begin
        errors++;
        $display("FAIL random_both_edges got r=%b f=%b exp disjoint",
          bus.rise_tick, bus.fall_tick);
      end
      edges += $countones(bus.rise_tick | bus.fall_tick);
    end
    checks++;
    if (edges == 0) begin
      errors++;
      $display("FAIL random_activity got edges=0 exp >0");
    end
    bus.en = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) m_ticks[c] = 0;
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_enable();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
